oled_num_render: RTL and testbench

OLED_NUM_RENDER -- requirements
Module: oled_num_render

---
 rtl/oled_pkg.sv | 27 ++
 rtl/oled_num_render.sv | 140 ++++++++++++++
 tb/tb_oled_num_render.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/oled_pkg.sv
// Shared definitions for the OLED numeric renderer: FSM state codes,
// SSD1306-style command opcodes and font geometry.
package oled_pkg;

   localparam logic [3:0] IDLE     = 4'd0;
   localparam logic [3:0] CMD_PAGE = 4'd1;
   localparam logic [3:0] CMD_COLL = 4'd2;
   localparam logic [3:0] CMD_COLH = 4'd3;
   localparam logic [3:0] ROM_ADDR = 4'd4;
   localparam logic [3:0] ROM_WAIT = 4'd5;
   localparam logic [3:0] DATA     = 4'd6;
   localparam logic [3:0] ROW_NEXT = 4'd7;
   localparam logic [3:0] FINISH   = 4'd8;

   localparam logic [7:0] OP_PAGE = 8'hB0;
   localparam logic [7:0] OP_COLL = 8'h00;
   localparam logic [7:0] OP_COLH = 8'h10;

   localparam int unsigned FONT_W    = 8;
   localparam int unsigned FONT_ROWS = 2;

   // Nibbles outside 0..9 are drawn as empty columns.
   function automatic logic is_blank(input logic [3:0] nib);
      return nib > 4'd9;
   endfunction

endpackage

// File: rtl/oled_num_render.sv
// Renders NUM_DIGITS BCD digits as two font rows on an OLED, issuing page/column
// commands then glyph bytes fetched from an external synchronous font ROM.
module oled_num_render
   import oled_pkg::*;
#(
   parameter int unsigned NUM_DIGITS = 4
) (
   input  logic                    sys_clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic [4*NUM_DIGITS-1:0] digits,
   input  logic [2:0]              page,
   input  logic [6:0]              col,
   output logic                    font_row,
   output logic [4:0]              font_sel,
   output logic [4:0]              index,
   input  logic [7:0]              rom_data,
   output logic                    wr_valid,
   output logic                    wr_dc,
   output logic [7:0]              wr_byte,
   input  logic                    wr_ready,
   output logic                    busy,
   output logic                    done
);

   localparam logic [2:0] LAST_DIG = 3'(NUM_DIGITS - 1);
   localparam logic [2:0] LAST_IDX = 3'(FONT_W - 1);
   localparam logic       LAST_ROW = 1'(FONT_ROWS - 1);

   logic [3:0]              state, state_n;
   logic [4*NUM_DIGITS-1:0] digits_q;
   logic [2:0]              page_q;
   logic [6:0]              col_q;
   logic                    row_q;
   logic [2:0]              dig_q;
   logic [2:0]              idx_q;
   logic [7:0]              data_q;
   logic [3:0]              nib;
   logic                    accept;
   logic                    last_byte;

   assign accept    = start && !busy;
   assign last_byte = (idx_q == LAST_IDX) && (dig_q == LAST_DIG);

   always_comb begin
      nib = '0;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
         if (dig_q == 3'(i)) nib = digits_q[4*(NUM_DIGITS-1-i) +: 4];
      end
   end

   assign font_row = row_q;
   assign font_sel = is_blank(nib) ? '0 : {1'b0, nib};
   assign index    = {2'b00, idx_q};

   always_comb begin
      state_n = state;
      case (state)
         IDLE, FINISH: state_n = start ? CMD_PAGE : IDLE;
         CMD_PAGE:     if (wr_ready) state_n = CMD_COLL;
         CMD_COLL:     if (wr_ready) state_n = CMD_COLH;
         CMD_COLH:     if (wr_ready) state_n = ROM_ADDR;
         ROM_ADDR:     state_n = ROM_WAIT;
         ROM_WAIT:     state_n = DATA;
         DATA: begin
            if (wr_ready) begin
               if (!last_byte)             state_n = ROM_ADDR;
               else if (row_q == LAST_ROW) state_n = FINISH;
               else                        state_n = ROW_NEXT;
            end
         end
         ROW_NEXT:     state_n = CMD_PAGE;
         default:      state_n = IDLE;
      endcase
   end

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         digits_q <= '0;
         page_q   <= '0;
         col_q    <= '0;
         row_q    <= 1'b0;
         dig_q    <= '0;
         idx_q    <= '0;
         data_q   <= '0;
      end else begin
         state <= state_n;
         if (accept) begin
            digits_q <= digits;
            page_q   <= page;
            col_q    <= col;
            row_q    <= 1'b0;
            dig_q    <= '0;
            idx_q    <= '0;
         end
         // ROM output is valid during ROM_WAIT; address is held by the counters.
         if (state == ROM_WAIT) data_q <= is_blank(nib) ? '0 : rom_data;
         if (state == DATA && wr_ready) begin
            if (idx_q == LAST_IDX) begin
               idx_q <= '0;
               dig_q <= (dig_q == LAST_DIG) ? '0 : dig_q + 3'd1;
            end else begin
               idx_q <= idx_q + 3'd1;
            end
         end
         if (state == ROW_NEXT) row_q <= 1'b1;
      end
   end

   always_comb begin
      wr_valid = 1'b0;
      wr_dc    = 1'b0;
      wr_byte  = '0;
      case (state)
         CMD_PAGE: begin
            wr_valid = 1'b1;
            wr_byte  = OP_PAGE | {5'b0, page_q + {2'b00, row_q}};
         end
         CMD_COLL: begin
            wr_valid = 1'b1;
            wr_byte  = OP_COLL | {4'h0, col_q[3:0]};
         end
         CMD_COLH: begin
            wr_valid = 1'b1;
            wr_byte  = OP_COLH | {5'b0, col_q[6:4]};
         end
         DATA: begin
            wr_valid = 1'b1;
            wr_dc    = 1'b1;
            wr_byte  = data_q;
         end
         default: ;
      endcase
   end

   assign busy = (state != IDLE) && (state != FINISH);
   assign done = (state == FINISH);

endmodule

// File: tb/tb_oled_num_render.sv
// Self-checking bench for oled_num_render: behavioural stream model, synchronous
// font ROM model, random stalls, ignored mid-render starts and reset abort.
module tb_oled_num_render;

   localparam int unsigned N  = 4;
   localparam int unsigned NB = 2 * (3 + 8 * N);

   logic           sys_clk = 1'b0;
   logic           rst_n;
   logic           start;
   logic [4*N-1:0] digits;
   logic [2:0]     page;
   logic [6:0]     col;
   logic           font_row;
   logic [4:0]     font_sel;
   logic [4:0]     index;
   logic [7:0]     rom_data;
   logic           wr_valid;
   logic           wr_dc;
   logic [7:0]     wr_byte;
   logic           wr_ready;
   logic           busy;
   logic           done;

   int n_checks = 0;
   int n_fail   = 0;
   int done_cnt = 0;
   bit stall_en = 1'b0;
   logic       pv_stall = 1'b0;
   logic [8:0] pv_word  = '0;
   logic [8:0] got_q[$];
   logic [8:0] exp_q[$];

   oled_num_render #(.NUM_DIGITS(N)) dut (
      .sys_clk  (sys_clk),
      .rst_n    (rst_n),
      .start    (start),
      .digits   (digits),
      .page     (page),
      .col      (col),
      .font_row (font_row),
      .font_sel (font_sel),
      .index    (index),
      .rom_data (rom_data),
      .wr_valid (wr_valid),
      .wr_dc    (wr_dc),
      .wr_byte  (wr_byte),
      .wr_ready (wr_ready),
      .busy     (busy),
      .done     (done)
   );

   always #5 sys_clk = ~sys_clk;

   function automatic logic [7:0] glyph(input int r, input int s, input int i);
      return 8'((s * 29 + i * 7 + r * 113 + 3) ^ (i << 4));
   endfunction

   always @(posedge sys_clk) rom_data <= glyph(int'(font_row), int'(font_sel), int'(index));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   initial begin
      wr_ready = 1'b1;
      forever begin
         @(posedge sys_clk);
         #1;
         wr_ready = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
   end

   // Transfer capture, stall stability and done pulse observation.
   always @(negedge sys_clk) begin
      if (rst_n && pv_stall) begin
         check("hold_valid", 32'(wr_valid), 32'd1);
         check("hold_word", 32'({wr_dc, wr_byte}), 32'(pv_word));
      end
      pv_stall <= rst_n && wr_valid && !wr_ready;
      pv_word  <= {wr_dc, wr_byte};
      if (wr_valid && wr_ready) got_q.push_back({wr_dc, wr_byte});
      if (done) begin
         done_cnt <= done_cnt + 1;
         check("done_busy", 32'(busy), 32'd0);
      end
   end

   task automatic build_exp(input logic [4*N-1:0] d, input logic [2:0] p, input logic [6:0] c);
      exp_q.delete();
      for (int r = 0; r < 2; r++) begin
         exp_q.push_back({1'b0, 8'hB0 | 8'((int'(p) + r) % 8)});
         exp_q.push_back({1'b0, 8'(int'(c) % 16)});
         exp_q.push_back({1'b0, 8'(16 + int'(c) / 16)});
         for (int k = 0; k < int'(N); k++) begin
            for (int i = 0; i < 8; i++) begin
               int nib;
               nib = int'((d >> (4 * (int'(N) - 1 - k))) & 16'hF);
               exp_q.push_back({1'b1, (nib > 9) ? 8'h00 : glyph(r, nib, i)});
            end
         end
      end
   endtask

   task automatic run(input string name, input logic [4*N-1:0] d, input logic [2:0] p,
                      input logic [6:0] c, input bit stall, input bit mid_start);
      int base;
      int cyc;
      build_exp(d, p, c);
      got_q.delete();
      base = done_cnt;
      stall_en = stall;
      @(posedge sys_clk);
      #1;
      digits = d;
      page   = p;
      col    = c;
      start  = 1'b1;
      @(posedge sys_clk);
      #1;
      start = 1'b0;
      check({name, "_busy"}, 32'(busy), 32'd1);
      cyc = 0;
      while (done_cnt == base && cyc < 4000) begin
         @(posedge sys_clk);
         #1;
         cyc++;
         if (mid_start && cyc == 20) begin
            start  = 1'b1;
            digits = ~d;
            page   = p + 3'd1;
            col    = c + 7'd5;
         end else if (cyc == 21) begin
            start = 1'b0;
         end
      end
      check({name, "_timeout"}, 32'(cyc < 4000), 32'd1);
      repeat (4) @(posedge sys_clk);
      #1;
      stall_en = 1'b0;
      check({name, "_done_pulses"}, 32'(done_cnt - base), 32'd1);
      check({name, "_idle_busy"}, 32'(busy), 32'd0);
      check({name, "_count"}, 32'(got_q.size()), 32'(NB));
      for (int i = 0; i < int'(NB) && i < got_q.size(); i++)
         check($sformatf("%s_w%0d", name, i), 32'(got_q[i]), 32'(exp_q[i]));
   endtask

   initial begin
      int cyc;
      int n_keep;
      rst_n  = 1'b0;
      start  = 1'b0;
      digits = '0;
      page   = '0;
      col    = '0;
      #12;
      check("rst_valid", 32'(wr_valid), 32'd0);
      check("rst_dc", 32'(wr_dc), 32'd0);
      check("rst_byte", 32'(wr_byte), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_font", 32'({font_row, font_sel, index}), 32'd0);
      @(posedge sys_clk);
      #1;
      rst_n = 1'b1;

      run("basic", 16'h1234, 3'd2, 7'd16, 1'b0, 1'b0);
      check("basic_cmd0", 32'(got_q[0]), 32'h0B2);
      check("basic_cmd1", 32'(got_q[1]), 32'h000);
      check("basic_cmd2", 32'(got_q[2]), 32'h011);
      check("basic_cmd3", 32'(got_q[35]), 32'h0B3);
      check("basic_cmd4", 32'(got_q[36]), 32'h000);
      check("basic_cmd5", 32'(got_q[37]), 32'h011);
      check("basic_d0", 32'(got_q[3]), 32'({1'b1, glyph(0, 1, 0)}));

      run("wrap", 16'($urandom), 3'd7, 7'($urandom_range(0, 127)), 1'b0, 1'b0);
      check("wrap_pg0", 32'(got_q[0]), 32'h0B7);
      check("wrap_pg1", 32'(got_q[35]), 32'h0B0);

      run("blank", 16'h9F05, 3'($urandom), 7'($urandom_range(0, 127)), 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) begin
         check($sformatf("blank_r0_%0d", i), 32'(got_q[11 + i]), 32'h100);
         check($sformatf("blank_r1_%0d", i), 32'(got_q[46 + i]), 32'h100);
      end

      for (int t = 0; t < 4; t++)
         run($sformatf("stall%0d", t), 16'($urandom), 3'($urandom),
             7'($urandom_range(0, 127)), 1'b1, 1'b0);

      run("midstart", 16'h5678, 3'd4, 7'd99, 1'b0, 1'b1);
      run("midstall", 16'($urandom), 3'($urandom), 7'($urandom_range(0, 127)), 1'b1, 1'b1);

      // Abort a render after ten transfers.
      got_q.delete();
      @(posedge sys_clk);
      #1;
      digits = 16'h4321;
      page   = 3'd1;
      col    = 7'd40;
      start  = 1'b1;
      @(posedge sys_clk);
      #1;
      start = 1'b0;
      cyc = 0;
      while (got_q.size() < 10 && cyc < 500) begin
         @(negedge sys_clk);
         cyc++;
      end
      check("abort_timeout", 32'(cyc < 500), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("abort_valid", 32'(wr_valid), 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_byte", 32'(wr_byte), 32'd0);
      n_keep = got_q.size();
      repeat (3) begin
         @(negedge sys_clk);
         check("abort_hold_valid", 32'(wr_valid), 32'd0);
      end
      @(posedge sys_clk);
      #1;
      rst_n = 1'b1;
      repeat (5) @(posedge sys_clk);
      #1;
      check("abort_no_xfer", 32'(got_q.size()), 32'(n_keep));

      run("after_rst", 16'h0987, 3'd6, 7'd127, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
